addsub_pipe: RTL and testbench

Parametrised, segmented, pipelined adder/subtractor for wide operands. The operand is split into `SEGMENTS` slices of `SEG_WIDTH` bits, and each slice's carry is registered into the next slice one stage later, so the critical path is one `SEG_WIDTH`-bit carry chain regardless of total width. The block adds a per-transaction add/sub mode, carry/borrow and signed-overflow flags, and a valid/ready handshake with full backpressure. It sits in the arithmetic library beside the two-stage subtractor and serves as the general wide add/sub for datapaths needing throughput of one operation per clock at any width.

---
 rtl/addsub_pipe_if.sv | 25 ++
 rtl/addsub_pipe.sv | 111 +++++++++++
 tb/tb_addsub_pipe.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_pipe_if.sv
// rtl/addsub_pipe_if.sv - operand/result handshake bundle for addsub_pipe
interface addsub_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] datao;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, mode, dataa, datab, out_ready,
    input  in_ready, out_valid, datao, carry, overflow
  );

  modport slave (
    input  in_valid, mode, dataa, datab, out_ready,
    output in_ready, out_valid, datao, carry, overflow
  );
endinterface

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - segmented pipelined add/sub with stall; ADDSUB_PIPE_SAT_EN adds signed clamp
module addsub_pipe #(
  parameter int SEG_WIDTH = 16,
  parameter int SEGMENTS  = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  addsub_pipe_if.slave bus
);
  localparam int WIDTH = SEG_WIDTH * SEGMENTS;
  localparam int TOP   = SEGMENTS - 1;

  logic                 advance;
  logic [WIDTH-1:0]     a_in    [SEGMENTS];
  logic [WIDTH-1:0]     b_in    [SEGMENTS];
  logic [WIDTH-1:0]     r_in    [SEGMENTS];
  logic [WIDTH-1:0]     res_w   [SEGMENTS];
  logic                 c_in    [SEGMENTS];
  logic                 m_in    [SEGMENTS];
  logic                 v_in    [SEGMENTS];
  logic [SEG_WIDTH:0]   seg_sum [SEGMENTS];

  logic [WIDTH-1:0]     a_st    [SEGMENTS];
  logic [WIDTH-1:0]     b_st    [SEGMENTS];
  logic [WIDTH-1:0]     r_st    [SEGMENTS];
  logic                 c_st    [SEGMENTS];
  logic                 m_st    [SEGMENTS];
  logic                 v_st    [SEGMENTS];
  logic                 carry_q;
  logic                 ovf_q;

  logic [SEG_WIDTH-1:0] top_low;
  logic                 top_cout;
  logic                 top_ovf;
  logic [WIDTH-1:0]     final_w;

  assign advance = !v_st[TOP] || bus.out_ready;

  for (genvar k = 0; k < SEGMENTS; k++) begin : g_seg
    logic [SEG_WIDTH-1:0] sa;
    logic [SEG_WIDTH-1:0] sb;
    if (k == 0) begin : g_first
      // Subtraction is A + ~B + 1; the +1 enters as segment 0's carry-in.
      assign a_in[k] = bus.dataa;
      assign b_in[k] = bus.mode ? ~bus.datab : bus.datab;
      assign r_in[k] = '0;
      assign c_in[k] = bus.mode;
      assign m_in[k] = bus.mode;
      assign v_in[k] = bus.in_valid;
    end else begin : g_next
      assign a_in[k] = a_st[k-1];
      assign b_in[k] = b_st[k-1];
      assign r_in[k] = r_st[k-1];
      assign c_in[k] = c_st[k-1];
      assign m_in[k] = m_st[k-1];
      assign v_in[k] = v_st[k-1];
    end
    assign sa         = a_in[k][k*SEG_WIDTH +: SEG_WIDTH];
    assign sb         = b_in[k][k*SEG_WIDTH +: SEG_WIDTH];
    assign seg_sum[k] = {1'b0, sa} + {1'b0, sb} + {{SEG_WIDTH{1'b0}}, c_in[k]};
    // Result slices above k are still zero here, so OR-ing inserts slice k.
    assign res_w[k]   = r_in[k] | (WIDTH'(seg_sum[k][SEG_WIDTH-1:0]) << (k * SEG_WIDTH));
  end

  // Carry into the MSB comes from the top segment's low SEG_WIDTH-1 bits.
  assign top_low  = {1'b0, a_in[TOP][WIDTH-2 -: SEG_WIDTH-1]}
                  + {1'b0, b_in[TOP][WIDTH-2 -: SEG_WIDTH-1]}
                  + {{(SEG_WIDTH-1){1'b0}}, c_in[TOP]};
  assign top_cout = seg_sum[TOP][SEG_WIDTH];
  assign top_ovf  = top_cout ^ top_low[SEG_WIDTH-1];

`ifdef ADDSUB_PIPE_SAT_EN
  assign final_w = !top_ovf            ? res_w[TOP] :
                   a_in[TOP][WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                         {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign final_w = res_w[TOP];
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < SEGMENTS; k++) begin
        a_st[k] <= '0;
        b_st[k] <= '0;
        r_st[k] <= '0;
        c_st[k] <= 1'b0;
        m_st[k] <= 1'b0;
        v_st[k] <= 1'b0;
      end
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < SEGMENTS; k++) begin
        a_st[k] <= a_in[k];
        b_st[k] <= b_in[k];
        r_st[k] <= (k == TOP) ? final_w : res_w[k];
        c_st[k] <= seg_sum[k][SEG_WIDTH];
        m_st[k] <= m_in[k];
        v_st[k] <= v_in[k];
      end
      carry_q <= top_cout ^ m_in[TOP];
      ovf_q   <= top_ovf;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v_st[TOP];
  assign bus.datao     = r_st[TOP];
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - bench for addsub_pipe (SEG_WIDTH=8, SEGMENTS=4); honours ADDSUB_PIPE_SAT_EN
module tb_addsub_pipe;
`ifdef ADDSUB_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        m;
    logic [31:0] d;
    logic        c;
    logic        o;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        c;
    logic        o;
  } res_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  addsub_pipe_if #(.WIDTH(32)) bus ();

  addsub_pipe #(.SEG_WIDTH(8), .SEGMENTS(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic m);
    res_t r;
    logic [32:0] s;
    if (!m) begin
      s   = {1'b0, a} + {1'b0, b};
      r.d = s[31:0];
      r.c = s[32];
      r.o = (a[31] == b[31]) && (r.d[31] != a[31]);
    end else begin
      r.d = a - b;
      r.c = (a < b);
      r.o = (a[31] != b[31]) && (r.d[31] != a[31]);
    end
    if (SAT && r.o) r.d = a[31] ? 32'h8000_0000 : 32'h7fff_ffff;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    bus.in_valid  = 1'b1;
    bus.mode      = v.m;
    bus.dataa     = v.a;
    bus.datab     = v.b;
    bus.out_ready = 1'b1;
    #1;
    check({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd4);
    check({name, " datao"}, 64'(bus.datao), 64'(v.d));
    check({name, " carry"}, 64'(bus.carry), 64'(v.c));
    check({name, " overflow"}, 64'(bus.overflow), 64'(v.o));
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hffff_ffff;
    corners[2] = 32'h7fff_ffff;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h0000_00ff;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  vec_t vecs [10];
  res_t expq [$];

  initial begin
    vecs[0] = '{32'h0000_00ff, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{32'hffff_ffff, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hffff_ffff, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b0, 1'b0};
    vecs[4] = '{32'h7fff_ffff, 32'h0000_0001, 1'b0, SAT ? 32'h7fff_ffff : 32'h8000_0000, 1'b0, 1'b1};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, SAT ? 32'h8000_0000 : 32'h7fff_ffff, 1'b0, 1'b1};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1, 1'b1};
    vecs[7] = '{32'h7fff_ffff, 32'hffff_ffff, 1'b1, SAT ? 32'h7fff_ffff : 32'h8000_0000, 1'b1, 1'b1};
    vecs[8] = '{32'h0000_ffff, 32'h00ff_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    vecs[9] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.mode      = 1'b0;
    bus.dataa     = '0;
    bus.datab     = '0;
    bus.out_ready = 1'b0;
    reset_n       = 1'b0;
    tick();
    tick();
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset datao", 64'(bus.datao), 64'd0);
    check("reset carry", 64'(bus.carry), 64'd0);
    check("reset overflow", 64'(bus.overflow), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    tick();

    // Random stream with backpressure against the arithmetic model.
    begin
      int          issued = 0;
      int          received = 0;
      int          cycles = 0;
      logic        stalled = 1'b0;
      logic [31:0] held_d = '0;
      logic        held_c = 1'b0;
      logic        held_o = 1'b0;
      res_t        r;
      while ((issued < 64 || received < 64) && cycles < 4000) begin
        bus.in_valid  = (issued < 64) && ($urandom_range(0, 3) != 0);
        bus.mode      = 1'($urandom_range(0, 1));
        bus.dataa     = pick_operand();
        bus.datab     = pick_operand();
        bus.out_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (stalled) begin
          check("stall out_valid", 64'(bus.out_valid), 64'd1);
          check("stall datao", 64'(bus.datao), 64'(held_d));
          check("stall flags", {62'd0, bus.carry, bus.overflow}, {62'd0, held_c, held_o});
        end
        if (bus.out_valid && !bus.out_ready) check("stall in_ready", 64'(bus.in_ready), 64'd0);
        if (bus.in_valid && bus.in_ready) begin
          expq.push_back(model(bus.dataa, bus.datab, bus.mode));
          issued++;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (expq.size() == 0) begin
            check("stream unexpected output", 64'd1, 64'd0);
          end else begin
            r = expq.pop_front();
            check($sformatf("stream%0d datao", received), 64'(bus.datao), 64'(r.d));
            check($sformatf("stream%0d flags", received), {62'd0, bus.carry, bus.overflow}, {62'd0, r.c, r.o});
          end
          received++;
        end
        stalled = bus.out_valid && !bus.out_ready;
        held_d  = bus.datao;
        held_c  = bus.carry;
        held_o  = bus.overflow;
        @(posedge clock);
        #1;
        cycles++;
      end
      check("stream received", 64'(received), 64'd64);
      check("stream queue empty", 64'(expq.size()), 64'd0);
    end

    // Reset with three items in flight: none may emerge afterwards.
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.mode     = 1'b0;
      bus.dataa    = 32'h1111_1111 * (i + 1);
      bus.datab    = 32'h0101_0101;
      tick();
    end
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    tick();
    check("midreset out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset datao", 64'(bus.datao), 64'd0);
    check("midreset in_ready", 64'(bus.in_ready), 64'd1);
    reset_n = 1'b1;
    begin
      int leaked = 0;
      for (int i = 0; i < 8; i++) begin
        if (bus.out_valid) leaked++;
        tick();
      end
      check("midreset leaked items", 64'(leaked), 64'd0);
    end
    run_vec("post-reset", vecs[0]);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
